// File: rtl/cpu_mem_responder.sv
// Arbitrates CPU imem/dmem requests onto one single-ported downstream memory.
// Define CPU_MEM_ARB_RR_EN for round-robin contention handling (default: dmem priority).
module cpu_mem_responder #(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_read,
    input  logic [31:0] imem_address,
    output logic        imem_resp,
    output logic [31:0] imem_rdata,
    input  logic        dmem_read,
    input  logic        dmem_write,
    input  logic [31:0] dmem_address,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic        dmem_resp,
    output logic [31:0] dmem_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic        mem_resp,
    input  logic [31:0] mem_rdata,
    output logic        err
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_I = 3'd1,
        BUSY_D = 3'd2,
        RESP_I = 3'd3,
        RESP_D = 3'd4
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             op_write_r;
    logic             dreq_s;
    logic             any_req_s;
    logic             grant_d_s;
    logic             unused_addr_s;

    // Byte offsets are dropped because the downstream memory is word-addressed.
    assign unused_addr_s = ^{imem_address[1:0], dmem_address[1:0]};

`ifdef CPU_MEM_ARB_RR_EN
    logic last_d_r;

    // Remember which port won the most recent grant; reset leaves dmem favoured.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_d_r <= 1'b0;
        end else if (state_r == IDLE && any_req_s) begin
            last_d_r <= grant_d_s;
        end else begin
            last_d_r <= last_d_r;
        end
    end
`endif

    // Pick the port to serve when the FSM is idle.
    always_comb begin
        dreq_s    = dmem_read | dmem_write;
        any_req_s = dreq_s | imem_read;
        grant_d_s = dreq_s;
        if (dreq_s && imem_read) begin
`ifdef CPU_MEM_ARB_RR_EN
            grant_d_s = ~last_d_r;
`else
            grant_d_s = 1'b1;
`endif
        end else begin
            grant_d_s = dreq_s;
        end
    end

    // Transaction FSM with registered downstream strobes and responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            op_write_r  <= 1'b0;
            imem_resp   <= 1'b0;
            imem_rdata  <= 32'h0000_0000;
            dmem_resp   <= 1'b0;
            dmem_rdata  <= 32'h0000_0000;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= 32'h0000_0000;
            mem_wmask   <= 4'b0000;
            mem_wdata   <= 32'h0000_0000;
            err         <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    cnt_r <= '0;
                    if (any_req_s && grant_d_s) begin
                        // A simultaneous read+write strobe is handled as a write.
                        op_write_r <= dmem_write;
                        if (dmem_write && dmem_wmask == 4'b0000) begin
                            state_r <= RESP_D;
                        end else begin
                            mem_address <= {dmem_address[31:2], 2'b00};
                            mem_wmask   <= dmem_write ? dmem_wmask : 4'b0000;
                            mem_wdata   <= dmem_write ? dmem_wdata : 32'h0000_0000;
                            mem_read    <= ~dmem_write;
                            mem_write   <= dmem_write;
                            state_r     <= BUSY_D;
                        end
                    end else if (any_req_s) begin
                        op_write_r  <= 1'b0;
                        mem_address <= {imem_address[31:2], 2'b00};
                        mem_wmask   <= 4'b0000;
                        mem_wdata   <= 32'h0000_0000;
                        mem_read    <= 1'b1;
                        mem_write   <= 1'b0;
                        state_r     <= BUSY_I;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (mem_resp) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        cnt_r     <= '0;
                        if (state_r == BUSY_I) begin
                            imem_resp  <= 1'b1;
                            imem_rdata <= mem_rdata;
                            state_r    <= RESP_I;
                        end else begin
                            dmem_resp  <= 1'b1;
                            dmem_rdata <= op_write_r ? 32'h0000_0000 : mem_rdata;
                            state_r    <= RESP_D;
                        end
                    end else if (cnt_r == CNT_LAST) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        cnt_r     <= '0;
                        err       <= 1'b1;
                        if (state_r == BUSY_I) begin
                            imem_resp  <= 1'b1;
                            imem_rdata <= 32'h0000_0000;
                            state_r    <= RESP_I;
                        end else begin
                            dmem_resp  <= 1'b1;
                            dmem_rdata <= 32'h0000_0000;
                            state_r    <= RESP_D;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                RESP_I: begin
                    if (!imem_resp) begin
                        imem_resp <= 1'b1;
                    end else begin
                        imem_resp  <= 1'b0;
                        imem_rdata <= 32'h0000_0000;
                        state_r    <= IDLE;
                    end
                end
                RESP_D: begin
                    // Zero-mask writes arrive here with the pulse not yet raised.
                    if (!dmem_resp) begin
                        dmem_resp <= 1'b1;
                    end else begin
                        dmem_resp  <= 1'b0;
                        dmem_rdata <= 32'h0000_0000;
                        state_r    <= IDLE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    imem_resp <= 1'b0;
                    dmem_resp <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder: vector table, randomized traffic
// against a word-memory reference model, and multi-cycle corner sequences.
module tb_cpu_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_read;
    logic [31:0] imem_address;
    logic        imem_resp;
    logic [31:0] imem_rdata;
    logic        dmem_read;
    logic        dmem_write;
    logic [31:0] dmem_address;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic        dmem_resp;
    logic [31:0] dmem_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic        mem_resp;
    logic [31:0] mem_rdata;
    logic        err;

    always #5 clk = ~clk;

    cpu_mem_responder #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .imem_read(imem_read), .imem_address(imem_address),
        .imem_resp(imem_resp), .imem_rdata(imem_rdata),
        .dmem_read(dmem_read), .dmem_write(dmem_write),
        .dmem_address(dmem_address), .dmem_wmask(dmem_wmask),
        .dmem_wdata(dmem_wdata), .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata), .err(err)
    );

`ifdef CPU_MEM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Downstream memory stub with programmable latency (0 = never answers)
    logic [31:0] mem_arr [0:255];
    int          ds_lat = 1;
    int          ds_acc = 0;
    logic [31:0] seen_addr, seen_wdata;
    logic [3:0]  seen_mask;

    initial begin
        int busy;
        logic [7:0] idx;
        for (int i = 0; i < 256; i++) mem_arr[i] = 32'h1000_0000 + 32'(i);
        mem_resp = 1'b0;
        mem_rdata = 32'h0;
        busy = 0;
        forever begin
            @(posedge clk); #1;
            mem_resp = 1'b0;
            mem_rdata = 32'h0;
            if (mem_read || mem_write) begin
                busy++;
                if (busy == ds_lat) begin
                    idx = mem_address[9:2];
                    mem_rdata = mem_arr[idx];
                    for (int b = 0; b < 4; b++)
                        if (mem_write && mem_wmask[b]) mem_arr[idx][8*b +: 8] = mem_wdata[8*b +: 8];
                    mem_resp = 1'b1;
                    seen_addr = mem_address;
                    seen_mask = mem_wmask;
                    seen_wdata = mem_wdata;
                    ds_acc++;
                    busy = 0;
                end
            end else begin
                busy = 0;
            end
        end
    end

    // Reference model: flat word memory plus arbitration rule
    logic [31:0] gold [0:255];

    function automatic bit model_pick_d(input bit d, input bit i, input bit last_d);
        if (d && i) return RR_EN ? !last_d : 1'b1;
        return d;
    endfunction

    typedef struct {
        bit          is_d;
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [3:0]  m;
        logic [31:0] wd;
        int          lat;
        logic [31:0] exp_rdata;
        int          exp_cyc;
        int          exp_acc;
        logic [3:0]  exp_mask;
        logic [31:0] exp_wd;
    } vec_t;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [159:0] all_outs();
        return {23'h0, imem_resp, imem_rdata, dmem_resp, dmem_rdata, mem_read, mem_write,
                mem_address, mem_wmask, mem_wdata, err};
    endfunction

    // Issue one request from IDLE; returns data, latency, strobe cycles, downstream accesses.
    task automatic do_txn(input vec_t v, output logic [31:0] rdata, output int cyc,
                          output int strb, output int acc);
        int acc0;
        acc0 = ds_acc;
        ds_lat = v.lat;
        if (v.is_d) begin
            dmem_read = v.rd; dmem_write = v.wr; dmem_address = v.addr;
            dmem_wmask = v.m; dmem_wdata = v.wd;
        end else begin
            imem_read = 1'b1; imem_address = v.addr;
        end
        cyc = 0;
        strb = 0;
        rdata = 32'h0;
        while (cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (mem_read || mem_write) strb++;
            if (v.is_d ? dmem_resp : imem_resp) begin
                rdata = v.is_d ? dmem_rdata : imem_rdata;
                break;
            end
        end
        dmem_read = 1'b0; dmem_write = 1'b0; imem_read = 1'b0;
        acc = ds_acc - acc0;
        @(posedge clk); #1;
        check("resp_pulse", {158'h0, imem_resp, dmem_resp}, 160'h0);
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        logic [31:0] rdata;
        int cyc, strb, acc;
        logic [7:0] idx;
        do_txn(v, rdata, cyc, strb, acc);
        check({tag, "_rdata"}, 160'(rdata), 160'(v.exp_rdata));
        check({tag, "_latency"}, 160'(cyc), 160'(v.exp_cyc));
        check({tag, "_accesses"}, 160'(acc), 160'(v.exp_acc));
        check({tag, "_strobe_cycles"}, 160'(strb), 160'(v.exp_acc != 0 ? v.lat : 0));
        if (v.exp_acc != 0) begin
            check({tag, "_mem_addr"}, 160'(seen_addr), 160'({v.addr[31:2], 2'b00}));
            check({tag, "_mem_mask_data"}, 160'({seen_mask, seen_wdata}), 160'({v.exp_mask, v.exp_wd}));
        end
        idx = v.addr[9:2];
        if (v.is_d && v.wr)
            for (int b = 0; b < 4; b++)
                if (v.m[b]) gold[idx][8*b +: 8] = v.wd[8*b +: 8];
    endtask

    task automatic do_reset();
        rst = 1'b1;
        imem_read = 1'b0; dmem_read = 1'b0; dmem_write = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("reset_outputs", all_outs(), 160'h0);
        rst = 1'b0;
    endtask

    vec_t tbl [9];

    initial begin
        vec_t v;
        logic [31:0] rd_d;
        int cyc, strb, acc, op;
        bit last_d, exp_d, got_d, dreq, seen;
        logic [7:0] idx;

        for (int i = 0; i < 256; i++) gold[i] = 32'h1000_0000 + 32'(i);
        imem_address = 32'h0; dmem_address = 32'h0; dmem_wmask = 4'h0; dmem_wdata = 32'h0;

        //        is_d rd   wr   addr          m      wd            lat exp_rdata   cyc acc mask   wd
        tbl[0] = '{1'b0, 1'b1, 1'b0, 32'h0000_0062, 4'h0, 32'h0,        3, 32'h1000_0018, 4, 1, 4'h0, 32'h0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 32'h0000_0100, 4'h5, 32'hDEAD_BEEF, 2, 32'h0,        3, 1, 4'h5, 32'hDEAD_BEEF};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 32'h0000_0102, 4'h0, 32'h0,        1, 32'h10AD_00EF, 2, 1, 4'h0, 32'h0};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 32'h0000_0104, 4'h0, 32'h1234_5678, 1, 32'h0,        2, 0, 4'h0, 32'h0};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 32'h0000_0104, 4'h0, 32'h0,        1, 32'h1000_0041, 2, 1, 4'h0, 32'h0};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 32'h0000_0108, 4'hF, 32'hCAFE_F00D, 2, 32'h0,        3, 1, 4'hF, 32'hCAFE_F00D};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 32'h0000_010B, 4'h0, 32'h0,        4, 32'hCAFE_F00D, 5, 1, 4'h0, 32'h0};
        tbl[7] = '{1'b1, 1'b0, 1'b1, 32'h0000_03FC, 4'h8, 32'hAB00_0000, 1, 32'h0,        2, 1, 4'h8, 32'hAB00_0000};
        tbl[8] = '{1'b0, 1'b1, 1'b0, 32'h0000_03FC, 4'h0, 32'h0,        2, 32'hAB00_00FF, 3, 1, 4'h0, 32'h0};

        do_reset();
        for (int i = 0; i < 9; i++) run_vec($sformatf("vec%0d", i), tbl[i]);
        check("err_clear_before_timeout", 160'(err), 160'h0);

        // Randomized single-requester traffic against the model
        for (int i = 0; i < 40; i++) begin
            v.is_d = 1'($urandom_range(0, 1));
            op = $urandom_range(0, 2);
            v.rd = !v.is_d || op != 1;
            v.wr = v.is_d && op != 0;
            v.addr = 32'($urandom_range(0, 1023));
            v.m = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            v.wd = $urandom;
            v.lat = $urandom_range(1, 5);
            idx = v.addr[9:2];
            v.exp_rdata = v.wr ? 32'h0 : gold[idx];
            v.exp_acc = (v.wr && v.m == 4'h0) ? 0 : 1;
            v.exp_cyc = (v.exp_acc == 0) ? 2 : v.lat + 1;
            v.exp_mask = v.wr ? v.m : 4'h0;
            v.exp_wd = v.wr ? v.wd : 32'h0;
            run_vec($sformatf("rand%0d", i), v);
        end

        // Downstream never answers: abort after 8 busy cycles
        v = '{1'b0, 1'b1, 1'b0, 32'h0000_0040, 4'h0, 32'h0, 0, 32'h0, 9, 0, 4'h0, 32'h0};
        do_txn(v, rd_d, cyc, strb, acc);
        check("timeout_latency", 160'(cyc), 160'd9);
        check("timeout_strobe_cycles", 160'(strb), 160'd8);
        check("timeout_rdata", 160'(rd_d), 160'h0);
        check("timeout_err", 160'(err), 160'h1);
        run_vec("after_timeout", tbl[8]);
        check("err_sticky", 160'(err), 160'h1);

        // Reset during the second busy cycle abandons the request
        ds_lat = 0;
        imem_read = 1'b1; imem_address = 32'h0000_0020;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midreset_outputs", all_outs(), 160'h0);
        rst = 1'b0; imem_read = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            seen = seen | imem_resp | dmem_resp | mem_read;
        end
        check("midreset_no_resp", 160'(seen), 160'h0);
        v = '{1'b0, 1'b1, 1'b0, 32'h0000_0024, 4'h0, 32'h0, 2, gold[9], 3, 1, 4'h0, 32'h0};
        run_vec("post_reset_imem", v);

        // Continuous contention: grant order follows the arbitration rule
        do_reset();
        last_d = 1'b0;
        dreq = 1'b1;
        ds_lat = 1;
        dmem_read = 1'b1; dmem_address = 32'h0000_0200;
        imem_read = 1'b1; imem_address = 32'h0000_0300;
        for (int t = 0; t < 5; t++) begin
            exp_d = model_pick_d(dreq, 1'b1, last_d);
            seen = 1'b0;
            got_d = 1'b0;
            for (int c = 0; c < 20 && !seen; c++) begin
                @(posedge clk); #1;
                if (imem_resp || dmem_resp) begin
                    seen = 1'b1;
                    got_d = dmem_resp;
                end
            end
            check($sformatf("contention_seen%0d", t), 160'(seen), 160'h1);
            check($sformatf("contention_grant%0d", t), 160'(got_d), 160'(exp_d));
            last_d = exp_d;
            if (t == 3) begin
                dmem_read = 1'b0;
                dreq = 1'b0;
            end
            if (t == 4) imem_read = 1'b0;
            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
